fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, ROM address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, instruction/ROM word width.
REQ-003 The block SHALL have port Clock, input, 1, single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Resetn, input, 1, reset: asynchronous, active-low.
REQ-005 The block SHALL have port Fetch, input, 1, request from control unit to fetch the next instruction.
REQ-006 The block SHALL have port PCload, input, 1, load PC from PCin (branch/jump).
REQ-007 The block SHALL have port PCin, input, ADDR_W, new PC value.
REQ-008 The block SHALL have port ROMout, input, DATA_W, synchronous ROM read data, valid one cycle after address is sampled.
REQ-009 The block SHALL have port ADDRout, output, ADDR_W, ROM address; combinationally equal to PC.
REQ-010 The block SHALL have port IR, output, DATA_W, instruction register.
REQ-011 The block SHALL have port PC, output, ADDR_W, current program counter.
REQ-012 The block SHALL have port Busy, output, 1, high in any state other than IDLE.
REQ-013 The block SHALL have port Done, output, 1, one-cycle pulse: IR holds the newly fetched word.

Function
REQ-014 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-015 In IDLE, with Fetch=1 at an edge: next state ISSUE; with Fetch=0: remain IDLE.
REQ-016 ISSUE SHALL last exactly one cycle; the ROM samples ADDRout at its closing edge; next state WAIT.
REQ-017 At the closing edge of WAIT: IR <= ROMout, PC <= PC+1, next state DONE.
REQ-018 DONE SHALL last exactly one cycle with Done=1; next state IDLE.
REQ-019 Latency: Fetch sampled at edge k -> IR updated and Done high after edge k+2; Busy low again after edge k+3.
REQ-020 PC increment SHALL be modulo 2^ADDR_W (31 -> 0 at default width); no flag, no stall.
REQ-021 PCload SHALL be honoured only in IDLE: PC <= PCin at that edge.
REQ-022 PCload=1 and Fetch=1 in the same IDLE cycle: PC <= PCin and state -> ISSUE; the fetch uses PCin.
REQ-023 Fetch and PCload outside IDLE SHALL be ignored (not queued); PC and IR unchanged except by REQ-017.
REQ-024 Fetch held high continuously SHALL produce back-to-back fetches, one every 4 cycles, at consecutive addresses.
REQ-025 IR SHALL change only at the WAIT closing edge or on reset; it holds its value in all other states.
REQ-026 ADDRout SHALL be stable during ISSUE and WAIT (PC unchanged until the WAIT closing edge).

Reset
REQ-027 Resetn=0 SHALL immediately, without a clock edge, force state IDLE, PC=0, IR=0, Done=0, Busy=0, ADDRout=0.
REQ-028 Reset asserted mid-fetch (ISSUE/WAIT/DONE) SHALL abort it: no IR load, no PC increment after deassertion.
REQ-029 After Resetn deasserts, the first edge with Fetch=1 SHALL start a fetch from address 0.

Verification
(Bench uses a synchronous ROM model, mem[i] = 16'hA000 + i, Clock period 2 time units.)
REQ-030 Reset, then single Fetch pulse -> ADDRout=0 through ISSUE/WAIT; Done high 1 cycle; IR=16'hA000; PC=1.
REQ-031 Fetch held high for 5 fetches -> IR sequence A000, A001, A002, A003, A004; Done pulses every 4 cycles; PC=5.
REQ-032 IDLE with PCload=1, PCin=5'd31, Fetch=1 -> IR=16'hA01F, PC wraps to 0; next fetch IR=16'hA000.
REQ-033 PCload=1, PCin=7 asserted during WAIT -> ignored; IR=mem[old PC], PC=old PC+1.
REQ-034 Resetn pulsed low during WAIT with PC=3, IR=A002 -> immediately PC=0, IR=0, Busy=0; no Done pulse follows.
REQ-035 Fetch pulsed high during ISSUE/DONE of an active fetch -> no additional fetch started; Busy drops after DONE.

Source files
------------

// File: rtl/fetch_unit.sv
`timescale 1ns/100ps
// Instruction fetch sequencer: IDLE -> ISSUE -> WAIT -> DONE around a
// synchronous ROM, loading IR and advancing PC once per fetch.
module fetch_unit #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Fetch,
    input  logic              PCload,
    input  logic [ADDR_W-1:0] PCin,
    input  logic [DATA_W-1:0] ROMout,
    output logic [ADDR_W-1:0] ADDRout,
    output logic [DATA_W-1:0] IR,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic              busy_q;
    logic              done_q;

    // Busy/Done are registered alongside the state so they switch
    // on the same edge as the state they describe.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (PCload)
                        pc_q <= PCin;
                    if (Fetch) begin
                        state_q <= S_ISSUE;
                        busy_q  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    ir_q    <= ROMout;
                    pc_q    <= pc_q + 1'b1;
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ADDRout = pc_q;
    assign PC      = pc_q;
    assign IR      = ir_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule
